latch_write_arbiter: RTL

LATCH_WRITE_ARBITER -- requirements
Module: latch_write_arbiter

---
 rtl/latch_write_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/latch_write_arbiter.sv
// Round-robin arbiter that serialises four requesters onto one shared latch bank,
// sequencing SETUP / OPEN / HOLD phases around a registered, glitch-free latch enable.
module latch_write_arbiter #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] wdata,
  output logic [3:0]         grant,
  output logic [WIDTH-1:0]   latch_d,
  output logic               latch_en,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] OPEN_LD  = 4'(OPEN_CYC - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

  state_t           r_state, w_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic [1:0]       r_ptr, w_win;
  logic             w_found, w_take;
  logic [3:0]       r_grant;
  logic [WIDTH-1:0] r_latch_d;
  logic             r_latch_en, r_done;

  // Scan downward from ptr+3 so the nearest requester above ptr is written last and wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[r_ptr + 2'(k)]) begin
        w_found = 1'b1;
        w_win   = r_ptr + 2'(k);
      end
    end
  end

  assign w_take = (r_state == IDLE) && w_found;

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      IDLE:  if (w_found) begin w_nxt = SETUP; w_cnt_nxt = SETUP_LD; end
      SETUP: if (r_cnt == 4'd0) begin w_nxt = OPEN; w_cnt_nxt = OPEN_LD; end
             else w_cnt_nxt = r_cnt - 4'd1;
      OPEN:  if (r_cnt == 4'd0) begin w_nxt = HOLD; w_cnt_nxt = HOLD_LD; end
             else w_cnt_nxt = r_cnt - 4'd1;
      HOLD:  if (r_cnt == 4'd0) begin w_nxt = IDLE; w_cnt_nxt = 4'd0; end
             else w_cnt_nxt = r_cnt - 4'd1;
      default: begin w_nxt = IDLE; w_cnt_nxt = 4'd0; end
    endcase
  end

  // latch_en is decoded from the next state so the pin itself is a flop output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_ptr      <= 2'd0;
      r_grant    <= 4'd0;
      r_latch_d  <= '0;
      r_latch_en <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_cnt      <= w_cnt_nxt;
      r_grant    <= w_take ? (4'b0001 << w_win) : 4'd0;
      r_latch_en <= (w_nxt == OPEN);
      r_done     <= (r_state == HOLD) && (r_cnt == 4'd0);
      if (w_take) begin
        r_ptr     <= w_win + 2'd1;
        r_latch_d <= wdata[w_win*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    busy     = (r_state != IDLE);
    grant    = r_grant;
    latch_d  = r_latch_d;
    latch_en = r_latch_en;
    done     = r_done;
  end

endmodule
